mem_arbiter: RTL

- Shares one single-port, fixed-latency memory between the pipelined ARM core's instruction-fetch stage and MEM stage.
- Grants one access at a time, with data accesses taking priority over fetches.
- Sequences the memory wait states and drives per-requester stall signals, so IF and MEM freeze until their access completes.
- Sits between the core stages and the shared memory; it replaces separate instruction and data memories.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_wait_counter.sv | 36 +++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding, the grant encoding and the wait-counter width.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_DATA
    } grant_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that paces the memory wait states.
// It raises a zero flag once the last wait cycle is reached.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // A load wins over a decrement; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch stage
// and the MEM stage; data accesses win, and each requester stalls until its ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_rd_req,
    input  logic              dm_wr_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    grant_e            gnt_q, gnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              dm_req;

    assign dm_req = dm_rd_req | dm_wr_req;

    arb_wait_counter u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(CNT_LOAD),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                // Both data strobes at once is illegal and falls through as a write.
                if (dm_req) begin
                    gnt_d       = GNT_DATA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_wr_req;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_load    = 1'b1;
                    state_d     = ACCESS;
                end else if (if_req) begin
                    gnt_d      = GNT_FETCH;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    cnt_load   = 1'b1;
                    state_d    = ACCESS;
                end else begin
                    mem_en_d = 1'b0;
                end
            end

            ACCESS: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    if ((gnt_q == GNT_DATA) && !mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    if (gnt_q == GNT_FETCH) begin
                        if_rdata_d = mem_rdata;
                    end
                    if_ready_d = (gnt_q == GNT_FETCH);
                    dm_ready_d = (gnt_q == GNT_DATA);
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = DONE;
                end
            end

            DONE: begin
                gnt_d   = GNT_NONE;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_NONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

    assign if_stall = if_req & ~if_ready_q;
    assign dm_stall = dm_req & ~dm_ready_q;

endmodule
